// File: rtl/dmem_responder.sv
// Data-memory responder: the slave end of the CPU load/store port.
// One request is accepted at a time. After WAIT_STATES extra cycles a
// one-cycle response pulse returns load data or an error flag.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W      = 4;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_d;
  logic               resp_valid_d;
  logic [31:0]        resp_rdata_d;
  logic               resp_err_d;

  logic               lat_write_q, lat_write_d;
  logic [31:0]        lat_addr_q, lat_addr_d;
  logic [31:0]        lat_wdata_q, lat_wdata_d;
  logic [3:0]         lat_be_q, lat_be_d;

  logic [31:0]        off_c;
  logic               err_c;
  logic [IDX_W-1:0]   idx_c;
  logic               mem_we_c;

  // Storage is deliberately outside reset so contents survive rst_n.
  logic [31:0]        mem [DEPTH_WORDS];

  // Decode of the latched address; addresses below BASE wrap high and fail.
  always_comb begin
    off_c = lat_addr_q - BASE_ADDR;
    err_c = (off_c >= SPAN_BYTES) || (lat_addr_q[1:0] != 2'b00);
    idx_c = off_c[IDX_W+1:2];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = req_ready;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_be_d     = lat_be_q;
    mem_we_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          lat_be_d    = req_be;
          state_d     = ST_WAIT;
          cnt_d       = '0;
          ready_d     = 1'b0;
        end else begin
          // First edge after reset release raises ready.
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          ready_d      = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = err_c;
          if (!err_c && !lat_write_q) begin
            resp_rdata_d = mem[idx_c];
          end
          mem_we_c = !err_c && lat_write_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, handshake, response and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 32'h0;
      lat_wdata_q <= 32'h0;
      lat_be_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready   <= ready_d;
      resp_valid  <= resp_valid_d;
      resp_rdata  <= resp_rdata_d;
      resp_err    <= resp_err_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
    end
  end

  // Byte-enabled store commit on the finish edge.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be_q[b]) begin
          mem[idx_c][8*b +: 8] <= lat_wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES=2 and 0) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk, rst_n;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];

  int checks, failures;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_be(req_be[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_be(req_be[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%h expected=%h", name, i, $time, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int i);
    checks++;
    failures++;
    $display("FAIL %s inst=%0d t=%0t actual=timeout expected=event", name, i, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  logic [31:0] mem_m [2][256];
  bit          m_pending[2];
  bit          m_ready  [2];
  int          m_due    [2];
  bit          m_write  [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_be     [2];
  logic        m_rv     [2];
  logic [31:0] m_rd     [2];
  logic        m_err    [2];
  int          cyc;
  int          accepts  [2];
  int          resps    [2];
  int          n_sent   [2];

  // Model advances on each edge; DUT outputs compared just after it.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 1'b0;
      m_rd[i] = 32'h0;
      m_err[i] = 1'b0;
      if (!rst_n) begin
        m_pending[i] = 1'b0;
        m_ready[i]   = 1'b0;
      end else if (m_pending[i] && cyc == m_due[i]) begin
        logic [31:0] off;
        bit bad;
        off = m_addr[i] - BASE;
        bad = (off >= 32'd1024) || (m_addr[i][1:0] != 2'b00);
        m_rv[i] = 1'b1;
        m_err[i] = bad;
        m_pending[i] = 1'b0;
        m_ready[i] = 1'b1;
        if (!bad) begin
          if (m_write[i]) begin
            for (int b = 0; b < 4; b++)
              if (m_be[i][b]) mem_m[i][off >> 2][8*b +: 8] = m_wdata[i][8*b +: 8];
          end else begin
            m_rd[i] = mem_m[i][off >> 2];
          end
        end
      end else if (!m_pending[i]) begin
        if (m_ready[i] && req_valid[i]) begin
          m_write[i] = req_write[i];
          m_addr[i]  = req_addr[i];
          m_wdata[i] = req_wdata[i];
          m_be[i]    = req_be[i];
          m_pending[i] = 1'b1;
          m_due[i]   = cyc + wait_of(i) + 1;
          m_ready[i] = 1'b0;
          accepts[i]++;
        end else begin
          m_ready[i] = 1'b1;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("req_ready", i, 32'(req_ready[i]), 32'(m_ready[i]));
      chk("resp_valid", i, 32'(resp_valid[i]), 32'(m_rv[i]));
      chk("resp_rdata", i, resp_rdata[i], m_rd[i]);
      chk("resp_err", i, 32'(resp_err[i]), 32'(m_err[i]));
      if (resp_valid[i] === 1'b1) resps[i]++;
    end
  end

  // ---------------- stimulus ----------------
  // Issue one request from a negedge and return the response. With garb set,
  // req_valid is held with junk during the busy cycles to prove it is ignored.
  task automatic do_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit garb,
                        output logic [31:0] rd, output logic e, output int lat);
    int t;
    rd = 32'h0; e = 1'b0; lat = 0;
    req_write[i] = wr; req_addr[i] = a; req_wdata[i] = wd; req_be[i] = be;
    req_valid[i] = 1'b1;
    t = 0;
    while (req_ready[i] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (req_ready[i] !== 1'b1) begin
      bound_fail("accept_wait", i);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    n_sent[i]++;
    @(negedge clk);
    if (garb) begin
      req_write[i] = 1'($urandom_range(0, 1));
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
      req_be[i]    = 4'($urandom);
    end else begin
      req_valid[i] = 1'b0;
    end
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) req_valid[i] = 1'b0;
      if (resp_valid[i] === 1'b1) break;
    end
    req_valid[i] = 1'b0;
    if (resp_valid[i] !== 1'b1) begin
      bound_fail("resp_wait", i);
      return;
    end
    rd = resp_rdata[i];
    e  = resp_err[i];
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    case (k)
      0:       a = BASE + 32'(1024 + 4 * $urandom_range(0, 63));
      1:       a = BASE - 32'(4 * $urandom_range(1, 64));
      2:       a = BASE + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
      default: a = BASE + 32'(4 * $urandom_range(0, 255));
    endcase
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old;
    logic e;
    int lat, t;
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0; req_be[i] = 4'h0;
      accepts[i] = 0; resps[i] = 0; n_sent[i] = 0;
      m_pending[i] = 1'b0; m_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 0, 32'(req_ready[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill both memories so every later load has a defined value.
    fork
      begin
        logic [31:0] r0; logic e0; int l0;
        for (int w = 0; w < 256; w++)
          do_req(0, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 1'b0, r0, e0, l0);
      end
      begin
        logic [31:0] r1; logic e1; int l1;
        for (int w = 0; w < 256; w++)
          do_req(1, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 1'b0, r1, e1, l1);
      end
    join

    // Full store then load, with latency pinned for WAIT_STATES=2.
    do_req(0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, e, lat);
    chk("t1_store_latency", 0, 32'(lat), 32'd3);
    chk("t1_store_err", 0, 32'(e), 32'h0);
    do_req(0, 1'b0, 32'h1001_0004, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("t1_load_data", 0, rd, 32'hDEAD_BEEF);

    // Partial and empty byte-enable stores.
    do_req(0, 1'b1, 32'h1001_0004, 32'h1122_3344, 4'b0101, 1'b0, rd, e, lat);
    do_req(0, 1'b0, 32'h1001_0004, 32'h0, 4'hF, 1'b0, rd, e, lat);
    chk("t2_partial_data", 0, rd, 32'hDE22_BE44);
    do_req(0, 1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'b0000, 1'b0, rd, e, lat);
    chk("t2_be0_err", 0, 32'(e), 32'h0);
    do_req(0, 1'b0, 32'h1001_0004, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("t2_be0_data", 0, rd, 32'hDE22_BE44);

    // Error cases and the last valid word.
    do_req(0, 1'b0, 32'h1001_0006, 32'h0, 4'hF, 1'b0, rd, e, lat);
    chk("t3_misaligned_err", 0, 32'(e), 32'h1);
    chk("t3_misaligned_rdata", 0, rd, 32'h0);
    do_req(0, 1'b1, 32'h1001_0400, 32'h1234_5678, 4'hF, 1'b0, rd, e, lat);
    chk("t3_past_end_err", 0, 32'(e), 32'h1);
    do_req(0, 1'b0, 32'h1000_FFFC, 32'h0, 4'hF, 1'b0, rd, e, lat);
    chk("t3_below_base_err", 0, 32'(e), 32'h1);
    chk("t3_below_base_rdata", 0, rd, 32'h0);
    do_req(0, 1'b1, 32'h1001_03FC, 32'h5A5A_A5A5, 4'hF, 1'b0, rd, e, lat);
    do_req(0, 1'b0, 32'h1001_03FC, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("t3_last_word_err", 0, 32'(e), 32'h0);
    chk("t3_last_word_data", 0, rd, 32'h5A5A_A5A5);

    // WAIT_STATES=0: store then load with req_valid held continuously.
    req_write[1] = 1'b1; req_addr[1] = 32'h1001_0010; req_wdata[1] = 32'h0BAD_CAFE;
    req_be[1] = 4'hF; req_valid[1] = 1'b1;
    t = 0;
    while (req_ready[1] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (req_ready[1] !== 1'b1) bound_fail("t4_store_accept", 1);
    @(posedge clk);
    n_sent[1]++;
    @(negedge clk);
    req_write[1] = 1'b0; req_wdata[1] = $urandom;
    t = 0;
    while (req_ready[1] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (req_ready[1] !== 1'b1) bound_fail("t4_load_accept", 1);
    @(posedge clk);
    n_sent[1]++;
    @(negedge clk);
    req_valid[1] = 1'b0;
    t = 0;
    while (resp_valid[1] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (resp_valid[1] !== 1'b1) bound_fail("t4_load_resp", 1);
    chk("t4_b2b_load_data", 1, resp_rdata[1], 32'h0BAD_CAFE);
    @(negedge clk);

    // Random traffic on both instances, junk valid during busy on WAIT_STATES=2.
    fork
      begin
        logic [31:0] r0; logic e0; int l0;
        for (int n = 0; n < 100; n++)
          do_req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), 1'b1, r0, e0, l0);
      end
      begin
        logic [31:0] r1; logic e1; int l1;
        for (int n = 0; n < 100; n++) begin
          do_req(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), 1'b0, r1, e1, l1);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("resp_count_vs_accepts", i, 32'(resps[i]), 32'(accepts[i]));
      chk("accepts_vs_sent", i, 32'(accepts[i]), 32'(n_sent[i]));
    end

    // Reset while a store is pending: no commit, no response.
    do_req(0, 1'b0, 32'h1001_0020, 32'h0, 4'h0, 1'b0, old, e, lat);
    req_write[0] = 1'b1; req_addr[0] = 32'h1001_0020; req_wdata[0] = 32'hCAFE_F00D;
    req_be[0] = 4'hF; req_valid[0] = 1'b1;
    t = 0;
    while (req_ready[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (req_ready[0] !== 1'b1) bound_fail("t6_accept", 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_ready_in_reset", 0, 32'(req_ready[0]), 32'h0);
    repeat (3) @(negedge clk);
    chk("t6_no_resp_in_reset", 0, 32'(resp_valid[0]), 32'h0);
    rst_n = 1'b1;
    chk("t6_ready_before_edge", 0, 32'(req_ready[0]), 32'h0);
    @(negedge clk);
    chk("t6_ready_after_edge", 0, 32'(req_ready[0]), 32'h1);
    repeat (3) @(negedge clk);
    do_req(0, 1'b0, 32'h1001_0020, 32'h0, 4'h0, 1'b0, rd, e, lat);
    chk("t6_store_dropped", 0, rd, old);
    chk("t6_not_cafef00d", 0, 32'(rd == 32'hCAFE_F00D), 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
